// File: rtl/dmem_bridge.sv
// dmem_bridge: data-memory bridge between the EX/MEM stage and a simple
// req/ack bus. It latches one request, holds it on the bus until the bus
// acknowledges, and stalls the pipeline while the access is in flight.
// A flush that arrives while the bus is busy lets the bus transaction finish
// but throws away its result.
//
// Optional feature: define DMEM_TIMEOUT_EN to add an 8-bit no-ack watchdog.
// It aborts a transaction after TIMEOUT_CYCLES cycles without an ack and
// pulses bus_err_o. When the macro is not defined, BUSY/ABORT wait forever
// and bus_err_o is tied low.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   mem_ce_i/_we_i     request valid / store (1) or load (0)
//   mem_sel_i          byte enables
//   mem_addr_i         physical address
//   mem_data_i         store data
//   flush_i            pipeline flush
//   bus_req_o          registered bus request
//   bus_we_o/_sel_o/_addr_o/_wdata_o  latched request attributes
//   bus_ack_i          bus completion strobe
//   bus_rdata_i        read data, valid while bus_ack_i is high
//   stallreq_o         combinational stall request
//   mem_rdata_o        registered load result
//   bus_err_o          one-cycle timeout pulse
module dmem_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stallreq_o,
  output logic [31:0] mem_rdata_o,
  output logic        bus_err_o
);

  // The watchdog counter is 8 bits wide, so the limit has to fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("dmem_bridge: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ABORT} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        accept;
  logic        waiting;   // bus owned and no ack this cycle
  logic        timeout;

  assign accept  = (state_q == IDLE) && mem_ce_i && !flush_i;
  assign waiting = ((state_q == BUSY) || (state_q == ABORT)) && !bus_ack_i;

`ifdef DMEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q;

  // cnt_q counts the no-ack cycles already spent. The cycle that would
  // bring the count up to TIMEOUT_CYCLES is the one that aborts.
  assign timeout = waiting && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (accept)       cnt_d = '0;
    else if (waiting) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout;
    end
  end

  assign bus_err_o = err_q;
`else
  assign timeout   = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = mem_we_i;
          sel_d   = mem_sel_i;
          addr_d  = mem_addr_i;
          wdata_d = mem_data_i;
          req_d   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus_ack_i) begin
          req_d = 1'b0;
          // A flush in the same cycle as the ack kills the result: the
          // access ends like an abort, with no DONE and no rdata update.
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            if (!we_q) rdata_d = bus_rdata_i;
            state_d = DONE;
          end
        end else if (timeout) begin
          req_d = 1'b0;
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            rdata_d = '0;
            state_d = DONE;
          end
        end else if (flush_i) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        if (bus_ack_i || timeout) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // In ABORT the killed access still owns the bus, so a new request has to
  // stall until the bridge is back in IDLE.
  assign stallreq_o = (state_q == BUSY) ||
                      (((state_q == IDLE) || (state_q == ABORT)) && mem_ce_i && !flush_i);

  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_sel_o   = sel_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign mem_rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
module tb_dmem_bridge;
`ifdef DMEM_TIMEOUT_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 255;
`endif

  logic        clk = 1'b0, rst = 1'b0;
  logic        mem_ce_i = 0, mem_we_i = 0, flush_i = 0, bus_ack_i = 0;
  logic [3:0]  mem_sel_i = 0;
  logic [31:0] mem_addr_i = 0, mem_data_i = 0, bus_rdata_i = 0;
  logic        bus_req_o, bus_we_o, stallreq_o, bus_err_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o, bus_wdata_o, mem_rdata_o;

  int n_chk = 0, n_fail = 0;

  dmem_bridge #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .rst(rst),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .flush_i(flush_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .stallreq_o(stallreq_o), .mem_rdata_o(mem_rdata_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Set inputs, then let combinational outputs settle before any check.
  task automatic drive(input logic ce, input logic we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic fl, input logic ack, input logic [31:0] rd);
    mem_ce_i = ce; mem_we_i = we; mem_sel_i = sel; mem_addr_i = addr;
    mem_data_i = data; flush_i = fl; bus_ack_i = ack; bus_rdata_i = rd;
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, mem_rdata_o, bus_err_o, stallreq_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b we=%b sel=%h addr=%h wd=%h rd=%h err=%b stall=%b, all required 0",
               bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, mem_rdata_o, bus_err_o, stallreq_o);
    end
  endtask

  task automatic test_load();
    int stall_cyc = 0, req_cyc = 0;
    drive(1, 0, 4'hF, 32'h10, 32'h0, 0, 0, 32'h0);   // accept cycle
    stall_cyc += int'(stallreq_o); req_cyc += int'(bus_req_o);
    tick();
    drive(1, 0, 4'hF, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF); // BUSY with ack
    stall_cyc += int'(stallreq_o); req_cyc += int'(bus_req_o);
    n_chk++;
    if (bus_addr_o !== 32'h10 || bus_we_o !== 1'b0 || bus_sel_o !== 4'hF) begin
      n_fail++; $display("FAIL load_attr: addr=%h we=%b sel=%h, required 00000010/0/f", bus_addr_o, bus_we_o, bus_sel_o);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);                     // DONE
    stall_cyc += int'(stallreq_o); req_cyc += int'(bus_req_o);
    n_chk++;
    if (mem_rdata_o !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_rdata: got %h, required deadbeef", mem_rdata_o);
    end
    tick();
    stall_cyc += int'(stallreq_o); req_cyc += int'(bus_req_o);
    n_chk++;
    if (stall_cyc != 2 || req_cyc != 1) begin
      n_fail++; $display("FAIL load_latency: stall cycles=%0d req cycles=%0d, required 2/1", stall_cyc, req_cyc);
    end
  endtask

  task automatic test_store();
    drive(1, 1, 4'hF, 32'h100, 32'h12345678, 0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 4'hF, 32'h100, 32'h12345678, 0, (i == 4), $urandom);
      n_chk++;
      if (!bus_req_o || !bus_we_o || bus_sel_o !== 4'hF || bus_addr_o !== 32'h100 ||
          bus_wdata_o !== 32'h12345678 || !stallreq_o) begin
        n_fail++;
        $display("FAIL store_hold[%0d]: req=%b we=%b sel=%h addr=%h wd=%h stall=%b, required 1/1/f/00000100/12345678/1",
                 i, bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, stallreq_o);
      end
      tick();
    end
    drive(1, 1, 4'hF, 32'h100, 32'h12345678, 0, 0, 0);  // DONE, ce still high
    n_chk++;
    if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0 || mem_rdata_o !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL store_done: stall=%b req=%b rd=%h, required 0/0/deadbeef", stallreq_o, bus_req_o, mem_rdata_o);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_flush();
    drive(1, 0, 4'h3, 32'h20, 0, 0, 0, 0);
    tick();
    drive(1, 0, 4'h3, 32'h20, 0, 0, 0, 0);             // BUSY 1
    tick();
    drive(0, 0, 0, 0, 0, 1, 0, 0);                     // BUSY 2 with flush
    n_chk++;
    if (!stallreq_o || !bus_req_o) begin
      n_fail++; $display("FAIL flush_busy: stall=%b req=%b, required 1/1", stallreq_o, bus_req_o);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);                     // ABORT, no ack
    n_chk++;
    if (!bus_req_o || stallreq_o || bus_addr_o !== 32'h20) begin
      n_fail++; $display("FAIL flush_abort_hold: req=%b stall=%b addr=%h, required 1/0/00000020", bus_req_o, stallreq_o, bus_addr_o);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 32'hAAAA5555);           // ABORT, ack
    tick();
    drive(1, 0, 4'hF, 32'h24, 0, 0, 0, 0);              // must be IDLE: accepts
    n_chk++;
    if (bus_req_o || mem_rdata_o !== 32'hDEADBEEF || !stallreq_o) begin
      n_fail++; $display("FAIL flush_idle: req=%b rd=%h stall=%b, required 0/deadbeef/1", bus_req_o, mem_rdata_o, stallreq_o);
    end
    tick();
    drive(1, 0, 4'hF, 32'h24, 0, 0, 1, 32'h0BADF00D);
    n_chk++;
    if (!bus_req_o || bus_addr_o !== 32'h24) begin
      n_fail++; $display("FAIL flush_next_accept: req=%b addr=%h, required 1/00000024", bus_req_o, bus_addr_o);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_mid_busy();
    drive(1, 0, 4'hF, 32'h40, 0, 0, 0, 0);
    tick();
    drive(1, 0, 4'hF, 32'h40, 0, 0, 0, 0);
    #2 rst = 1'b1;                                     // between edges
    #1;
    n_chk++;
    if (bus_req_o !== 1'b0 || mem_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_async: req=%b rd=%h, required 0/00000000", bus_req_o, mem_rdata_o);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 32'h5A5A5A5A);           // stray ack
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (bus_req_o || stallreq_o || mem_rdata_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_stray_ack: req=%b stall=%b rd=%h, required 0/0/00000000", bus_req_o, stallreq_o, mem_rdata_o);
    end
  endtask

  task automatic test_timeout();
    drive(1, 0, 4'hF, 32'h80, 0, 0, 0, 0);
    tick();
`ifdef DMEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 4'hF, 32'h80, 0, 0, 0, 0);
      n_chk++;
      if (!bus_req_o || bus_err_o) begin
        n_fail++; $display("FAIL to_wait[%0d]: req=%b err=%b, required 1/0", i, bus_req_o, bus_err_o);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);                     // DONE
    n_chk++;
    if (!bus_err_o || bus_req_o || mem_rdata_o !== 32'h0 || stallreq_o) begin
      n_fail++; $display("FAIL to_fire: err=%b req=%b rd=%h stall=%b, required 1/0/00000000/0", bus_err_o, bus_req_o, mem_rdata_o, stallreq_o);
    end
    tick();
    n_chk++;
    if (bus_err_o || bus_req_o) begin
      n_fail++; $display("FAIL to_pulse: err=%b req=%b, required 0/0", bus_err_o, bus_req_o);
    end
`else
    for (int i = 0; i < 300; i++) begin
      drive(1, 0, 4'hF, 32'h80, 0, 0, 0, 0);
      n_chk++;
      if (!bus_req_o || bus_err_o || !stallreq_o) begin
        n_fail++; $display("FAIL wait_forever[%0d]: req=%b err=%b stall=%b, required 1/0/1", i, bus_req_o, bus_err_o, stallreq_o);
      end
      tick();
    end
    drive(1, 0, 4'hF, 32'h80, 0, 0, 1, 32'h13579BDF);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (mem_rdata_o !== 32'h13579BDF) begin
      n_fail++; $display("FAIL late_ack_rdata: got %h, required 13579bdf", mem_rdata_o);
    end
    tick();
`endif
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 4'hF, 32'h200, 0, 0, 0, 0);
    tick();
    drive(1, 0, 4'hF, 32'h200, 0, 0, 1, 32'h11111111);
    tick();
    drive(1, 0, 4'hF, 32'h200, 0, 0, 0, 0);             // DONE, ce high
    n_chk++;
    if (stallreq_o || bus_req_o) begin
      n_fail++; $display("FAIL b2b_done: stall=%b req=%b, required 0/0", stallreq_o, bus_req_o);
    end
    tick();
    drive(1, 0, 4'hF, 32'h204, 0, 0, 0, 0);             // IDLE: next load
    n_chk++;
    if (!stallreq_o) begin
      n_fail++; $display("FAIL b2b_idle_stall: stall=%b, required 1", stallreq_o);
    end
    tick();
    drive(1, 0, 4'hF, 32'h204, 0, 0, 1, 32'h22222222);
    n_chk++;
    if (!bus_req_o || bus_addr_o !== 32'h204 || mem_rdata_o !== 32'h11111111) begin
      n_fail++; $display("FAIL b2b_second: req=%b addr=%h rd=%h, required 1/00000204/11111111", bus_req_o, bus_addr_o, mem_rdata_o);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  // Transaction-level reference: one outstanding access at a time, a
  // "killed" flag for flushed accesses, and a one-cycle completion slot.
  task automatic test_random();
    logic        m_out = 0, m_killed = 0, m_done = 0, m_err = 0;
    logic        m_we = 0;
    logic [3:0]  m_sel = 0;
    logic [31:0] m_addr = 0, m_wd = 0, m_rd = 0;
    int          m_wait = 0;
    logic        e_stall, ce, we, fl, ack;
    logic [31:0] rd, ad, wd;
    logic [3:0]  sel;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      ce = ($urandom_range(0, 1) == 1); we = ($urandom_range(0, 1) == 1);
      fl = ($urandom_range(0, 9) == 0); ack = ($urandom_range(0, 3) == 0);
      sel = 4'($urandom); ad = $urandom; wd = $urandom; rd = $urandom;
      drive(ce, we, sel, ad, wd, fl, ack, rd);
      e_stall = m_done ? 1'b0 : ((m_out && !m_killed) ? 1'b1 : (ce && !fl));
      n_chk++;
      if (bus_req_o !== m_out || stallreq_o !== e_stall || mem_rdata_o !== m_rd ||
          bus_err_o !== m_err || bus_we_o !== m_we || bus_sel_o !== m_sel ||
          bus_addr_o !== m_addr || bus_wdata_o !== m_wd) begin
        n_fail++;
        $display("FAIL rand[%0d]: req=%b stall=%b rd=%h err=%b we=%b sel=%h addr=%h wd=%h, required %b/%b/%h/%b/%b/%h/%h/%h",
                 c, bus_req_o, stallreq_o, mem_rdata_o, bus_err_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
                 m_out, e_stall, m_rd, m_err, m_we, m_sel, m_addr, m_wd);
      end
      tick();
      // model update for the edge just taken
      m_err = 1'b0;
      if (m_done) begin
        m_done = 1'b0;
      end else if (!m_out) begin
        if (ce && !fl) begin
          m_out = 1; m_killed = 0; m_wait = 0;
          m_we = we; m_sel = sel; m_addr = ad; m_wd = wd;
        end
      end else if (ack) begin
        m_out = 0;
        if (!m_killed && !fl) begin
          if (!m_we) m_rd = rd;
          m_done = 1;
        end
      end else begin
`ifdef DMEM_TIMEOUT_EN
        if (m_wait + 1 == TB_TO) begin
          m_out = 0; m_err = 1;
          if (!m_killed && !fl) begin m_rd = 0; m_done = 1; end
        end else if (fl) m_killed = 1;
`else
        if (fl) m_killed = 1;
`endif
        m_wait++;
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_flush();
    test_reset_mid_busy();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the BUSY/ABORT cycles without ack before abort; used only when DMEM_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port mem_ce_i  input  1  memory request from the EX/MEM stage for the current instruction.
REQ-005 SHALL have port mem_we_i  input  1  1 = store, 0 = load.
REQ-006 SHALL have port mem_sel_i  input  4  byte enables.
REQ-007 SHALL have port mem_addr_i  input  32  physical address.
REQ-008 SHALL have port mem_data_i  input  32  store data.
REQ-009 SHALL have port flush_i  input  1  pipeline flush (exception).
REQ-010 SHALL have port bus_req_o  output  1  bus request, registered.
REQ-011 SHALL have ports bus_we_o (1), bus_sel_o (4), bus_addr_o (32) and bus_wdata_o (32), all outputs, giving the latched request attributes.
REQ-012 SHALL have port bus_ack_i  input  1  bus completion strobe.
REQ-013 SHALL have port bus_rdata_i  input  32  read data, valid with bus_ack_i.
REQ-014 SHALL have port stallreq_o  output  1  stall request to the pipeline controller, combinational.
REQ-015 SHALL have port mem_rdata_o  output  32  load result, registered.
REQ-016 SHALL have port bus_err_o  output  1  one-cycle timeout pulse.

Function
REQ-017 SHALL implement states IDLE, BUSY, DONE and ABORT.
REQ-018 In IDLE with mem_ce_i=1 and flush_i=0, SHALL latch we/sel/addr/wdata into the bus_* registers, set bus_req_o=1 and go to BUSY.
REQ-019 In IDLE with flush_i=1, SHALL ignore mem_ce_i and stay in IDLE.
REQ-020 In BUSY, SHALL hold bus_req_o and all bus_* outputs stable until bus_ack_i=1.
REQ-021 On bus_ack_i=1 in BUSY, SHALL clear bus_req_o, load bus_rdata_i into mem_rdata_o if bus_we_o=0 (else hold it), and go to DONE.
REQ-022 DONE SHALL last exactly one cycle and then go to IDLE unconditionally.
REQ-023 flush_i=1 in BUSY SHALL go to ABORT; the bus transaction still completes.
REQ-024 On bus_ack_i=1 in ABORT, SHALL clear bus_req_o, leave mem_rdata_o unchanged and go to IDLE.
REQ-025 bus_ack_i SHALL be ignored in IDLE, DONE and ABORT-after-ack.
REQ-026 stallreq_o SHALL equal (IDLE and mem_ce_i and not flush_i) or BUSY or (ABORT and mem_ce_i and not flush_i).
REQ-027 stallreq_o SHALL be 0 in DONE.
REQ-028 Minimum load latency SHALL be 3 cycles (accept, BUSY with ack, DONE); each extra cycle without ack adds one.

Reset
REQ-029 On rst=1, SHALL go asynchronously to IDLE, drive bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, mem_rdata_o and bus_err_o to 0, and clear the timeout counter.
REQ-030 Reset during BUSY or ABORT SHALL drop bus_req_o immediately, and the first ack after reset SHALL be ignored.

Configuration
REQ-031 With DMEM_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entering BUSY and increment each BUSY/ABORT cycle without ack; on reaching TIMEOUT_CYCLES, SHALL clear bus_req_o, pulse bus_err_o for one cycle, and go to DONE from BUSY with mem_rdata_o=0, or to IDLE from ABORT.
REQ-032 With DMEM_TIMEOUT_EN undefined, there SHALL be no counter, bus_err_o SHALL be tied 0, and BUSY/ABORT SHALL wait indefinitely.

Verification
REQ-033 Load at 0x00000010 with ack in the first BUSY cycle and rdata 0xDEADBEEF -> stallreq_o high 2 cycles, mem_rdata_o=0xDEADBEEF in DONE, bus_req_o high 1 cycle.
REQ-034 Store sel=0xF, data 0x12345678, ack after 4 wait cycles -> bus_* stable for 5 cycles, mem_rdata_o unchanged, stallreq_o falls in DONE.
REQ-035 flush_i=1 in the second BUSY cycle, ack 2 cycles later with rdata 0xAAAA5555 -> bus_req_o held until ack, mem_rdata_o unchanged, return to IDLE with no DONE.
REQ-036 rst asserted mid-BUSY, then a stray ack -> bus_req_o=0 asynchronously, state IDLE, ack ignored.
REQ-037 With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, load with no ack -> bus_err_o pulses after 4 BUSY cycles, mem_rdata_o=0, then DONE and IDLE.
REQ-038 Back-to-back loads with mem_ce_i held high -> second request is accepted in the IDLE cycle right after DONE.
